scene_sequencer: RTL
====================

# scene_sequencer

Per-frame animation controller and colour compositor for the VGA shape layers. Once per frame it advances the anchor position of `N_SHAPES` triangle generators, each bouncing inside the visible area. During active video it merges their per-pixel hit flags by fixed priority into one registered RGB pixel. It sits between the VGA timing generator (`x`, `y`, `disp_en`) and the shape generators: it drives their anchors and consumes their hits.

## Interface
- `H`, 1280: visible width in pixels.
- `V`, 1024: visible height in lines.
- `N_SHAPES`, 3: number of shape layers (1..4).
- `SIZE`, 150: shape bounding-box edge, used as the bounce margin.
- `STEP`, 2: pixels moved per frame on each axis.
- `INIT_X`, 100 / `INIT_Y`, 100 / `SPACING`, 300: shape i resets to (`INIT_X`+i·`SPACING`, `INIT_Y`).

Ports:
- `VGA_CLK`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `disp_en`  in  1  active-video qualifier.
- `x`, `y`  in  11 each  current pixel coordinates.
- `hit`  in  `N_SHAPES`  hit flag from shape generator i (bit i).
- `anchor_x`, `anchor_y`  out  11·`N_SHAPES` each  packed anchors; shape i occupies bits [11i+10:11i].
- `r`, `g`, `b`  out  8 each  registered pixel colour.

## Operation
- FSM states:
  - ACTIVE: compositing.
  - UPDATE: walks shape index `idx` 0..`N_SHAPES`−1, one shape per cycle.
- ACTIVE→UPDATE on `frame_tick`. UPDATE→ACTIVE after `idx`=`N_SHAPES`−1 is processed.
- `frame_tick`: register set in the cycle after `disp_en`=1 with `x`=`H`−1 and `y`=`V`−1 is sampled. It is ignored while in UPDATE.
- Per shape, X axis; Y is identical, using `V`:
  - dir +: if ax+`STEP` > `H`−`SIZE`, ax←`H`−`SIZE` and dir flips to −; otherwise ax←ax+`STEP`.
  - dir −: if ax < `STEP`, ax←0 and dir flips to +; otherwise ax←ax−`STEP`.
  - Sums are computed 12 bits wide; anchors never wrap.
- Compositor, in ACTIVE or UPDATE:
  - `disp_en`=0: next rgb = 0.
  - `disp_en`=1: lowest set index in `hit` wins, and its palette colour is used.
  - No hit: background colour.
- Palette: shape 0 = ff/00/00, 1 = 00/ff/00, 2 = 00/00/ff, 3 = ff/ff/00; background = 00/00/00.

## Timing
- Reset values:
  - `r`/`g`/`b` = 0.
  - Anchors = init positions; all directions = +x, +y.
  - State = ACTIVE; `frame_tick` = 0; `idx` = 0.
- Pixel latency is one cycle: `hit`/`disp_en` at cycle n produce rgb at n+1. Shape generators must present `hit` aligned with `x`/`y`.
- UPDATE starts the cycle after `frame_tick` is set and lasts exactly `N_SHAPES` cycles. Shape i's anchor updates at cycle i+1 after the tick. All updates fall in blanking.
- Reset mid-UPDATE: all anchors return to init, whether already updated or not, and the state returns to ACTIVE.

## Configuration
- `SCENE_PAUSE_EN` defined:
  - Adds input `pause` (1 bit).
  - If `pause`=1 when `frame_tick` is set, UPDATE is skipped for that frame; anchors and directions hold.
  - Compositing is unaffected.
- Undefined: no `pause` port; every frame updates.

## Structure
- Package `scene_pkg`:
  - palette constants.
  - background constant.
  - FSM state enum (ACTIVE, UPDATE).
  - `rgb_t` struct (r, g, b bytes).
- Sub-module `bounce_axis`: one axis step (pos, dir, limit, step → next pos, next dir). Instantiated twice and time-shared by `idx`.

## Test plan
- Reset: after `reset` release, anchors are shape 0 (100,100), shape 1 (400,100), shape 2 (700,100); rgb=0.
- One frame sweep, no hits: one cycle after (1279,1023), UPDATE runs 3 cycles; shape 0 is then at (102,102), directions unchanged.
- Right-edge bounce: force shape 0 ax=1129, dir + (`H`−`SIZE`=1130); after a tick, ax=1130 and dir −; after the next tick, ax=1128.
- Priority: `hit`=3'b110 with `disp_en`=1 → next-cycle rgb=00/ff/00. `hit`=3'b111 → ff/00/00. Any `hit` with `disp_en`=0 → 0.
- Reset mid-UPDATE: assert `reset` on UPDATE cycle 2. Shape 0 must return to (100,100), state ACTIVE, and no further anchor changes until the next tick.
- `SCENE_PAUSE_EN`: `pause`=1 across two frame ticks leaves anchors unchanged. Drop `pause`, and the next tick advances each anchor by 2.

Source files
------------

// File: rtl/scene_pkg.sv
// scene_pkg: shared types and constants for the scene sequencer.
// Holds the palette, the background colour, the FSM state type and the RGB struct.
package scene_pkg;

  localparam int COORD_W = 11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    ACTIVE = 1'b0,
    UPDATE = 1'b1
  } scene_state_e;

  localparam rgb_t PAL_SHAPE0 = '{r: 8'hff, g: 8'h00, b: 8'h00};
  localparam rgb_t PAL_SHAPE1 = '{r: 8'h00, g: 8'hff, b: 8'h00};
  localparam rgb_t PAL_SHAPE2 = '{r: 8'h00, g: 8'h00, b: 8'hff};
  localparam rgb_t PAL_SHAPE3 = '{r: 8'hff, g: 8'hff, b: 8'h00};
  localparam rgb_t BACKGROUND = '{r: 8'h00, g: 8'h00, b: 8'h00};

  // Colour assigned to a shape layer.
  function automatic rgb_t palette(input logic [1:0] layer);
    rgb_t c;
    case (layer)
      2'd0:    c = PAL_SHAPE0;
      2'd1:    c = PAL_SHAPE1;
      2'd2:    c = PAL_SHAPE2;
      default: c = PAL_SHAPE3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/scene_sequencer_bounce_axis.sv
// bounce_axis: one axis step of a bouncing anchor.
// Moves pos by step in the current direction, clamping to [0, limit] and
// reversing direction when an edge would be crossed. Sums are one bit wider
// than the coordinate so the comparison never sees a wrapped value.
module bounce_axis
  import scene_pkg::*;
(
  input  logic [COORD_W-1:0] i_pos,
  input  logic               i_dir,   // 1 = increasing, 0 = decreasing
  input  logic [COORD_W-1:0] i_limit,
  input  logic [COORD_W-1:0] i_step,
  output logic [COORD_W-1:0] o_pos,
  output logic               o_dir
);

  logic [COORD_W:0] w_sum;

  // Next position and direction for one frame step.
  always_comb begin
    w_sum = {1'b0, i_pos} + {1'b0, i_step};
    o_pos = i_pos;
    o_dir = i_dir;
    if (i_dir) begin
      if (w_sum > {1'b0, i_limit}) begin
        o_pos = i_limit;
        o_dir = 1'b0;
      end else begin
        o_pos = w_sum[COORD_W-1:0];
      end
    end else begin
      if (i_pos < i_step) begin
        o_pos = '0;
        o_dir = 1'b1;
      end else begin
        o_pos = i_pos - i_step;
      end
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// scene_sequencer: per-frame animation of N_SHAPES bouncing anchors plus a
// fixed-priority colour compositor for the shape hit flags.
// Optional build macro: SCENE_PAUSE_EN adds a 'pause' input that skips the
// per-frame anchor update while held high at the frame tick.
//
// state  | meaning
// ACTIVE | compositing only, waiting for the end-of-frame tick
// UPDATE | stepping shape r_idx, one shape per cycle, then back to ACTIVE
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int H        = 1280,
  parameter int V        = 1024,
  parameter int N_SHAPES = 3,
  parameter int SIZE     = 150,
  parameter int STEP     = 2,
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 100,
  parameter int SPACING  = 300
) (
  input  logic                        VGA_CLK,
  input  logic                        reset,
`ifdef SCENE_PAUSE_EN
  input  logic                        pause,
`endif
  input  logic                        disp_en,
  input  logic [COORD_W-1:0]          x,
  input  logic [COORD_W-1:0]          y,
  input  logic [N_SHAPES-1:0]         hit,
  output logic [COORD_W*N_SHAPES-1:0] anchor_x,
  output logic [COORD_W*N_SHAPES-1:0] anchor_y,
  output logic [7:0]                  r,
  output logic [7:0]                  g,
  output logic [7:0]                  b
);

  localparam int IDX_W = (N_SHAPES > 1) ? $clog2(N_SHAPES) : 1;
  localparam logic [COORD_W-1:0] LIM_X    = COORD_W'(H - SIZE);
  localparam logic [COORD_W-1:0] LIM_Y    = COORD_W'(V - SIZE);
  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] LAST_X   = COORD_W'(H - 1);
  localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(V - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_SHAPES - 1);

  scene_state_e        r_state;
  logic                r_frame_tick;
  logic [IDX_W-1:0]    r_idx;
  logic [COORD_W-1:0]  r_ax [N_SHAPES];
  logic [COORD_W-1:0]  r_ay [N_SHAPES];
  logic [N_SHAPES-1:0] r_dir_x;
  logic [N_SHAPES-1:0] r_dir_y;
  rgb_t                r_pix;

  logic [COORD_W-1:0]  w_cur_x;
  logic [COORD_W-1:0]  w_cur_y;
  logic                w_cur_dx;
  logic                w_cur_dy;
  logic [COORD_W-1:0]  w_nxt_x;
  logic [COORD_W-1:0]  w_nxt_y;
  logic                w_nxt_dx;
  logic                w_nxt_dy;
  logic                w_pause;
  rgb_t                w_pix;

`ifdef SCENE_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  function automatic logic [COORD_W-1:0] init_x(input int i);
    return COORD_W'(INIT_X + i * SPACING);
  endfunction

  // The two axis steppers are shared across shapes, selected by r_idx.
  assign w_cur_x  = r_ax[r_idx];
  assign w_cur_y  = r_ay[r_idx];
  assign w_cur_dx = r_dir_x[r_idx];
  assign w_cur_dy = r_dir_y[r_idx];

  bounce_axis u_axis_x (
    .i_pos   (w_cur_x),
    .i_dir   (w_cur_dx),
    .i_limit (LIM_X),
    .i_step  (STEP_C),
    .o_pos   (w_nxt_x),
    .o_dir   (w_nxt_dx)
  );

  bounce_axis u_axis_y (
    .i_pos   (w_cur_y),
    .i_dir   (w_cur_dy),
    .i_limit (LIM_Y),
    .i_step  (STEP_C),
    .o_pos   (w_nxt_y),
    .o_dir   (w_nxt_dy)
  );

  // Frame tick: one-cycle pulse after the last visible pixel is sampled.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= disp_en && (x == LAST_X) && (y == LAST_Y);
    end
  end

  // Sequencer FSM: owns the anchors and directions; ticks during UPDATE are dropped.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_state <= ACTIVE;
      r_idx   <= '0;
      for (int i = 0; i < N_SHAPES; i++) begin
        r_ax[i] <= init_x(i);
        r_ay[i] <= COORD_W'(INIT_Y);
      end
      r_dir_x <= '1;
      r_dir_y <= '1;
    end else begin
      case (r_state)
        ACTIVE: begin
          r_idx <= '0;
          if (r_frame_tick && !w_pause) begin
            r_state <= UPDATE;
          end
        end
        UPDATE: begin
          r_ax[r_idx]    <= w_nxt_x;
          r_ay[r_idx]    <= w_nxt_y;
          r_dir_x[r_idx] <= w_nxt_dx;
          r_dir_y[r_idx] <= w_nxt_dy;
          if (r_idx == LAST_IDX) begin
            r_state <= ACTIVE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= ACTIVE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Priority merge: scanning from the top index down leaves the lowest hit winning.
  always_comb begin
    w_pix = BACKGROUND;
    for (int i = N_SHAPES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        w_pix = palette(2'(i));
      end
    end
  end

  // Registered pixel: black outside active video, otherwise the merged colour.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_pix <= '0;
    end else if (disp_en) begin
      r_pix <= w_pix;
    end else begin
      r_pix <= '0;
    end
  end

  // Flatten the anchor arrays onto the packed output buses.
  always_comb begin
    anchor_x = '0;
    anchor_y = '0;
    for (int i = 0; i < N_SHAPES; i++) begin
      anchor_x[COORD_W*i +: COORD_W] = r_ax[i];
      anchor_y[COORD_W*i +: COORD_W] = r_ay[i];
    end
  end

  assign r = r_pix.r;
  assign g = r_pix.g;
  assign b = r_pix.b;

endmodule
